polynomial_matrix_multiplication: RTL and testbench



---
 rtl/polynomial_matrix_multiplication.sv | 72 +++++++
 tb/tb_polynomial_matrix_multiplication.sv | 132 +++++++++++++
 2 files changed

// File: rtl/polynomial_matrix_multiplication.sv
// rtl/polynomial_matrix_multiplication.sv - registered negacyclic polynomial multiplier over Z_Q[x]/(x^N+1)
module polynomial_matrix_multiplication #(
    parameter int N = 4,
    parameter int Q = 17,
    parameter int W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic signed [W-1:0] polynomial1    [N-1:0],
    input  logic signed [W-1:0] polynomial2    [N-1:0],
    output logic signed [W-1:0] polynomial_out [N-1:0]
);

    // Accumulator wide enough that N full 2W-bit products never wrap.
    localparam int AW = 2 * W + $clog2(N) + 1;
    localparam logic signed [AW-1:0] QS = AW'(Q);

    logic signed [AW-1:0] acc      [N-1:0];
    logic signed [AW-1:0] rem      [N-1:0];
    logic signed [AW-1:0] prod;
    logic signed [W-1:0]  product_d[N-1:0];
    logic signed [W-1:0]  out_d    [N-1:0];
    logic signed [W-1:0]  out_q    [N-1:0];

    always_comb begin
        prod = '0;
        for (int k = 0; k < N; k++) begin
            acc[k] = '0;
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                prod = AW'(polynomial1[i]) * AW'(polynomial2[j]);
                // Terms landing at or beyond x^N fold back negated since x^N = -1.
                if (i + j < N) begin
                    acc[i + j] = acc[i + j] + prod;
                end else begin
                    acc[i + j - N] = acc[i + j - N] - prod;
                end
            end
        end
        for (int k = 0; k < N; k++) begin
            rem[k] = acc[k] % QS;
            if (rem[k] < 0) begin
                rem[k] = rem[k] + QS;
            end
            product_d[k] = W'(rem[k]);
        end
    end

    always_comb begin
        for (int k = 0; k < N; k++) begin
            out_d[k] = out_q[k];
            if (enable) begin
                out_d[k] = product_d[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (!rst_n) begin
                out_q[k] <= '0;
            end else begin
                out_q[k] <= out_d[k];
            end
        end
    end

    assign polynomial_out = out_q;

endmodule

// File: tb/tb_polynomial_matrix_multiplication.sv
// tb/tb_polynomial_matrix_multiplication.sv - randomized self-checking bench against a modular-arithmetic model
module tb_polynomial_matrix_multiplication;

    typedef int vec_t [4];

    logic               clk;
    logic               rst_n;
    logic               enable;
    logic signed [31:0] p1   [3:0];
    logic signed [31:0] p2   [3:0];
    logic signed [31:0] pout [3:0];

    int   passed;
    int   total;
    vec_t exp_q;

    polynomial_matrix_multiplication #(.N(4), .Q(17), .W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .polynomial1    (p1),
        .polynomial2    (p2),
        .polynomial_out (pout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int fmod(input longint x);
        longint r;
        r = x % 17;
        if (r < 0) r += 17;
        return int'(r);
    endfunction

    // Reduce operands first so the exact ring product stays tiny.
    function automatic void model(input vec_t a, input vec_t b, output vec_t c);
        longint s [4];
        for (int k = 0; k < 4; k++) s[k] = 0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (i + j < 4) s[i + j]     += longint'(fmod(a[i])) * fmod(b[j]);
                else           s[i + j - 4] -= longint'(fmod(a[i])) * fmod(b[j]);
            end
        end
        for (int k = 0; k < 4; k++) c[k] = fmod(s[k]);
    endfunction

    task automatic check(input string tag, input int obs, input int expv);
        total++;
        if (obs == expv) passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    endtask

    task automatic step(input vec_t a, input vec_t b, input logic en, input logic rn, input string tag);
        vec_t c;
        for (int k = 0; k < 4; k++) begin
            p1[k] = a[k];
            p2[k] = b[k];
        end
        enable = en;
        rst_n  = rn;
        @(posedge clk);
        if (!rn) begin
            exp_q = '{0, 0, 0, 0};
        end else if (en) begin
            model(a, b, c);
            exp_q = c;
        end
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s[%0d]", tag, k), int'(pout[k]), exp_q[k]);
        end
    endtask

    initial begin
        vec_t a;
        vec_t b;
        passed = 0;
        total  = 0;
        exp_q  = '{0, 0, 0, 0};
        rst_n  = 1'b0;
        enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            p1[k] = 0;
            p2[k] = 0;
        end
        @(negedge clk);

        step('{5, 6, 7, 8}, '{9, 10, 11, 12}, 1'b1, 1'b0, "reset");
        step('{5, 6, 7, 8}, '{9, 10, 11, 12}, 1'b1, 1'b1, "reset_release");
        step('{1, 0, 0, 0}, '{3, 5, 7, 11}, 1'b1, 1'b1, "identity");
        step('{0, 1, 0, 0}, '{1, 2, 3, 4}, 1'b1, 1'b1, "wrap_x");
        step('{1, 1, 1, 1}, '{1, 1, 1, 1}, 1'b1, 1'b1, "all_ones");
        step('{-1, 0, 0, 0}, '{1, 2, 3, 4}, 1'b1, 1'b1, "neg_one");
        step('{18, 0, 0, 0}, '{20, 0, 0, 0}, 1'b1, 1'b1, "oversized");
        step('{1, 0, 0, 0}, '{1, 2, 3, 4}, 1'b1, 1'b1, "hold_load");
        step('{7, 3, 9, 2}, '{4, 4, 4, 4}, 1'b0, 1'b1, "hold1");
        step('{-9, 30, 1, 6}, '{2, 8, -5, 1}, 1'b0, 1'b1, "hold2");
        step('{2, 0, 0, 0}, '{1, 1, 1, 1}, 1'b1, 1'b1, "b2b_0");
        step('{0, 0, 1, 0}, '{1, 2, 3, 4}, 1'b1, 1'b1, "b2b_1");
        step('{0, 0, 0, 1}, '{5, 6, 7, 8}, 1'b1, 1'b1, "b2b_2");
        step('{3, 3, 3, 3}, '{3, 3, 3, 3}, 1'b1, 1'b0, "reset_over_en");

        for (int n = 0; n < 80; n++) begin
            logic en;
            logic rn;
            en = ($urandom_range(0, 3) != 0);
            rn = ($urandom_range(0, 15) != 0);
            for (int k = 0; k < 4; k++) begin
                if (n % 2 == 0) begin
                    a[k] = int'($urandom_range(0, 40)) - 20;
                    b[k] = int'($urandom_range(0, 40)) - 20;
                end else begin
                    a[k] = int'($urandom);
                    b[k] = int'($urandom);
                end
            end
            if (n == 79) begin
                a = '{32'h7fffffff, 32'h80000000, -1, 32'h80000000};
                b = '{32'h80000000, 32'h80000000, 32'h7fffffff, -1};
                en = 1'b1;
                rn = 1'b1;
            end
            step(a, b, en, rn, $sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
